// File: rtl/fruit_spawner.sv
// fruit_spawner: placement source for the fruit object.
// Draws pseudo-random top-left coordinates from a 16-bit LFSR and loads them
// into the fruit with a one-cycle illegalPlacement strobe. It then watches one
// full video frame for scenery overlap and re-rolls the position on overlap,
// falling back to a fixed position once the retries run out. After the monkey
// eats the fruit, it respawns once a frame-count delay has elapsed.
//
// Ports:
//   clk, resetN        clock, asynchronous active-low reset
//   startOfFrame       one-cycle pulse at each frame start
//   enable             game running; 0 parks the FSM in IDLE
//   fruitOverlap       fruit pixel coincides with scenery this cycle
//   monkeyCollision    monkey touches the fruit this cycle
//   randomX, randomY   candidate/committed top-left position (11 bits)
//   illegalPlacement   one-cycle load strobe to the fruit
//   fruitLive          fruit committed and edible
//   fruitsEaten        saturating eat counter
//   retryCount         overlap re-rolls used for the current spawn
module fruit_spawner #(
    parameter int          X_MIN          = 0,
    parameter int          X_MAX          = 575,
    parameter int          Y_MIN          = 32,
    parameter int          Y_MAX          = 415,
    parameter int          RESPAWN_FRAMES = 60,
    parameter int          MAX_RETRIES    = 15,
    parameter int          FALLBACK_X     = 288,
    parameter int          FALLBACK_Y     = 64,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        fruitOverlap,
    input  logic        monkeyCollision,
    output logic [10:0] randomX,
    output logic [10:0] randomY,
    output logic        illegalPlacement,
    output logic        fruitLive,
    output logic [7:0]  fruitsEaten,
    output logic [3:0]  retryCount
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAW, S_LOAD, S_ARM, S_PROBE, S_FORCE, S_LIVE, S_WAIT
    } state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic               sticky;
    logic [CNT_W-1:0]   frameCnt;

    logic [10:0] cx;
    logic [10:0] cy;
    int          cxI;
    int          cyI;
    logic        inRange;
    logic        overlapSeen;
    logic [15:0] lfsrNext;

    // Candidate position and its legality window
    assign cx      = {1'b0, lfsr[9:0]};
    assign cy      = {2'b0, lfsr[15:7]};
    assign cxI     = int'(cx);
    assign cyI     = int'(cy);
    assign inRange = (cxI >= X_MIN) && (cxI <= X_MAX) &&
                     (cyI >= Y_MIN) && (cyI <= Y_MAX);

    // Fibonacci LFSR, taps 16/14/13/11
    assign lfsrNext = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Overlap over the whole probe frame, including the closing frame pulse
    assign overlapSeen = sticky | fruitOverlap;

    // Spawn FSM with registered outputs. The strobe is raised one cycle after
    // the position is latched, so randomX/randomY are already settled when the
    // fruit samples them.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= S_IDLE;
            lfsr             <= LFSR_SEED;
            randomX          <= 11'(FALLBACK_X);
            randomY          <= 11'(FALLBACK_Y);
            illegalPlacement <= 1'b0;
            fruitLive        <= 1'b0;
            fruitsEaten      <= 8'd0;
            retryCount       <= 4'd0;
            sticky           <= 1'b0;
            frameCnt         <= '0;
        end else begin
            illegalPlacement <= 1'b0;
            if (!enable) begin
                // A same-cycle eat still counts even though the game stops
                state      <= S_IDLE;
                fruitLive  <= 1'b0;
                retryCount <= 4'd0;
                if (state == S_LIVE && monkeyCollision && fruitsEaten != 8'hFF)
                    fruitsEaten <= fruitsEaten + 8'd1;
            end else begin
                case (state)
                    S_IDLE: state <= S_DRAW;
                    S_DRAW: begin
                        lfsr <= lfsrNext;
                        if (inRange) begin
                            randomX <= cx;
                            randomY <= cy;
                            state   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        illegalPlacement <= 1'b1;
                        sticky           <= 1'b0;
                        state            <= S_ARM;
                    end
                    S_ARM: begin
                        if (startOfFrame)
                            state <= S_PROBE;
                    end
                    S_PROBE: begin
                        if (!startOfFrame) begin
                            sticky <= overlapSeen;
                        end else if (!overlapSeen) begin
                            fruitLive <= 1'b1;
                            state     <= S_LIVE;
                        end else if (retryCount < 4'(MAX_RETRIES)) begin
                            retryCount <= retryCount + 4'd1;
                            state      <= S_DRAW;
                        end else begin
                            randomX <= 11'(FALLBACK_X);
                            randomY <= 11'(FALLBACK_Y);
                            state   <= S_FORCE;
                        end
                    end
                    S_FORCE: begin
                        illegalPlacement <= 1'b1;
                        fruitLive        <= 1'b1;
                        state            <= S_LIVE;
                    end
                    S_LIVE: begin
                        if (monkeyCollision) begin
                            if (fruitsEaten != 8'hFF)
                                fruitsEaten <= fruitsEaten + 8'd1;
                            frameCnt  <= CNT_W'(RESPAWN_FRAMES);
                            fruitLive <= 1'b0;
                            state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (frameCnt == '0) begin
                            retryCount <= 4'd0;
                            state      <= S_DRAW;
                        end else if (startOfFrame) begin
                            frameCnt <= frameCnt - CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fruit_spawner.sv
module tb_fruit_spawner;

    localparam int F = 32;

    logic        clk, resetN, sof, enable, ovl, mc, zero, one;
    logic [10:0] rx, ry, rx0, ry0;
    logic        ip, live, ip0, live0;
    logic [7:0]  eaten, eaten0;
    logic [3:0]  retry, retry0;

    fruit_spawner #(.RESPAWN_FRAMES(3)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
        .fruitOverlap(ovl), .monkeyCollision(mc), .randomX(rx), .randomY(ry),
        .illegalPlacement(ip), .fruitLive(live), .fruitsEaten(eaten),
        .retryCount(retry));

    fruit_spawner #(.RESPAWN_FRAMES(0)) dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(one),
        .fruitOverlap(zero), .monkeyCollision(one), .randomX(rx0), .randomY(ry0),
        .illegalPlacement(ip0), .fruitLive(live0), .fruitsEaten(eaten0),
        .retryCount(retry0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: expected placements and live events per spawn
    typedef struct { int x; int y; int r; bit frc; int min_sof; } place_t;
    typedef struct { int r; bit frc; } live_t;
    place_t pq[$];
    live_t  lq[$];

    logic [15:0] m_lfsr;
    int eaten_m;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic next_cand(output int x, output int y);
        do begin
            x = int'(m_lfsr[9:0]);
            y = int'(m_lfsr[15:7]);
            m_lfsr = lfsr_step(m_lfsr);
        end while (!(x >= 0 && x <= 575 && y >= 32 && y <= 415));
    endtask

    // Driver-side plan: overlap modes chosen per placement attempt
    int cyc = 0, sof_cnt = 0, sofs = 99, att = 0, plan_k = 0, mode = 0;

    // k = number of overlapping probe attempts (>=16 means fallback)
    task automatic plan_spawn(input int k, input int min_sof);
        int n, x, y;
        n = (k >= 16) ? 16 : k + 1;
        for (int i = 0; i < n; i++) begin
            next_cand(x, y);
            pq.push_back('{x, y, i, 1'b0, (i == 0) ? min_sof : 0});
        end
        if (k >= 16) pq.push_back('{288, 64, 15, 1'b1, 0});
        lq.push_back('{(k >= 16) ? 15 : k, k >= 16});
        plan_k = k;
        att = 0;
        sofs = 99;
    endtask

    // Frame pulses and overlap stimulus.
    // mode 0: overlap only before/at ARM exit (must be ignored)
    // mode 1: overlap inside the probe frame, not at its closing pulse
    // mode 2: overlap only in the closing-pulse cycle
    initial begin
        sof = 1'b0;
        ovl = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            sof = (cyc % F == 0);
            if (sof) sof_cnt++;
            if (ip) begin
                mode = (att < plan_k) ? int'($urandom_range(1, 2)) : 0;
                att++;
                sofs = sof ? 1 : 0;
            end else if (sof) begin
                sofs++;
            end
            if (sofs == 0 || (sofs == 1 && sof)) ovl = (mode == 0);
            else if (sofs == 1)                  ovl = (mode == 1) && ($urandom_range(0, 3) == 0);
            else if (sofs == 2 && sof)           ovl = (mode == 2);
            else                                 ovl = ($urandom_range(0, 3) == 0);
        end
    end

    // Scoreboard monitor for the main instance
    int  prev_x = 0, prev_y = 0;
    bit  prev_ip = 0, prev_live = 0, prev_sof = 0;
    initial begin
        place_t p;
        live_t  l;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                prev_ip   = 0;
                prev_live = 0;
            end else begin
                if (ip) begin
                    check("ip_back_to_back", int'(prev_ip), 0);
                    check("x_stable_before_ip", int'(rx), prev_x);
                    check("y_stable_before_ip", int'(ry), prev_y);
                    if (pq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ip: got x=%0d y=%0d expected no strobe", rx, ry);
                    end else begin
                        p = pq.pop_front();
                        check("place_x", int'(rx), p.x);
                        check("place_y", int'(ry), p.y);
                        check("place_retry", int'(retry), p.r);
                        check("force_with_live", int'(live), int'(p.frc));
                        check("respawn_delay_ok", int'(sof_cnt >= p.min_sof), 1);
                    end
                end
                if (live && !prev_live) begin
                    if (lq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_live: got live=1 expected 0");
                    end else begin
                        l = lq.pop_front();
                        check("live_retry", int'(retry), l.r);
                        if (!l.frc) check("live_after_frame", int'(prev_sof), 1);
                    end
                end
                prev_ip   = ip;
                prev_live = live;
            end
            prev_x   = int'(rx);
            prev_y   = int'(ry);
            prev_sof = sof;
        end
    end

    // Saturation monitor for the zero-delay instance (collision held high)
    int eats0 = 0, exp0 = 0;
    bit pend0 = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!resetN) begin
                eats0 = 0;
                exp0  = 0;
                pend0 = 0;
            end else begin
                if (pend0) begin
                    check("sat_count", int'(eaten0), exp0);
                    pend0 = 0;
                end
                if (ip0)
                    check("d0_range", int'(rx0 <= 575 && ry0 >= 32 && ry0 <= 415), 1);
                if (live0) begin
                    check("d0_retry", int'(retry0), 0);
                    eats0++;
                    exp0  = (exp0 < 255) ? exp0 + 1 : 255;
                    pend0 = 1;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_x"}, int'(rx), 288);
        check({tag, "_y"}, int'(ry), 64);
        check({tag, "_ip"}, int'(ip), 0);
        check({tag, "_live"}, int'(live), 0);
        check({tag, "_eaten"}, int'(eaten), 0);
        check({tag, "_retry"}, int'(retry), 0);
    endtask

    task automatic wait_live();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!live && n < 3000);
        if (!live) begin
            checks++;
            errors++;
            $display("FAIL live_timeout: got live=0 expected 1 within 3000 cycles");
        end
        repeat ($urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic wait_ip();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ip && n < 500);
        if (!ip) begin
            checks++;
            errors++;
            $display("FAIL ip_timeout: got ip=0 expected 1 within 500 cycles");
        end
    endtask

    task automatic wait_sof();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sof && n < 2 * F);
    endtask

    task automatic eat(input int nk, input bit use_min);
        int sat;
        @(posedge clk);
        #1 mc = 1'b1;
        @(negedge clk);
        check("live_at_eat", int'(live), 1);
        sat = sof_cnt;
        @(posedge clk);
        #1 mc = 1'b0;
        @(negedge clk);
        eaten_m = (eaten_m < 255) ? eaten_m + 1 : 255;
        check("eaten", int'(eaten), eaten_m);
        check("live_after_eat", int'(live), 0);
        plan_spawn(nk, use_min ? sat + 3 : 0);
    endtask

    initial begin
        int nk, n_ip, n;
        zero    = 1'b0;
        one     = 1'b1;
        resetN  = 1'b0;
        enable  = 1'b0;
        mc      = 1'b0;
        m_lfsr  = 16'hACE1;
        eaten_m = 0;
        repeat (3) @(negedge clk);
        check_reset("rst");

        // Start; a collision outside LIVE must be ignored
        plan_spawn(0, 0);
        @(posedge clk);
        #1 resetN = 1'b1;
        enable = 1'b1;
        mc     = 1'b1;
        @(posedge clk);
        #1 mc = 1'b0;

        // Asynchronous reset in the middle of the probe frame
        wait_ip();
        if (!sof) wait_sof();
        repeat (5) @(negedge clk);
        resetN = 1'b0;
        #1 check_reset("rst_probe");
        pq.delete();
        lq.delete();
        m_lfsr = 16'hACE1;
        plan_spawn(0, 0);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;

        // Spawn / eat cycles with random overlap patterns, incl. fallback
        for (int s = 0; s < 8; s++) begin
            wait_live();
            nk = (s == 0) ? 1 : (s == 6) ? 16 : (s == 7) ? 2 : int'($urandom_range(0, 3));
            eat(nk, 1'b1);
        end

        // Enable drop while waiting to respawn
        wait_live();
        eat(0, 1'b0);
        wait_sof();
        repeat (3) @(negedge clk);
        check("wait_retry_kept", int'(retry), 2);
        check("wait_not_live", int'(live), 0);
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_live", int'(live), 0);
        check("idle_retry", int'(retry), 0);
        check("idle_eaten_kept", int'(eaten), eaten_m);
        n_ip = 0;
        repeat (10) begin
            @(negedge clk);
            if (ip) n_ip++;
        end
        check("idle_no_ip", n_ip, 0);
        @(posedge clk);
        #1 enable = 1'b1;
        wait_live();

        // Let the zero-delay instance run past 255 eats
        n = 0;
        while (eats0 < 256 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("sat_eats_reached", int'(eats0 >= 256), 1);
        check("sat_final", int'(eaten0), 255);
        check("main_eaten_final", int'(eaten), eaten_m);
        check("queues_drained", pq.size() + lq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fruit_spawner.md
# fruit_spawner

Placement source for the fruit object. Generates pseudo-random candidate top-left coordinates, loads them into the fruit with a one-cycle `illegalPlacement` pulse, and watches one full video frame for overlap with scenery. Re-rolls on overlap; respawns after a frame-count delay once the monkey eats the fruit. Sits between the frame timing/collision logic and the fruit object, and drives the fruit's `randomX`, `randomY` and `illegalPlacement` inputs.

## Interface
- `X_MIN`, default 0: smallest legal top-left X.
- `X_MAX`, default 575: largest legal top-left X (639 − 64).
- `Y_MIN`, default 32: smallest legal top-left Y.
- `Y_MAX`, default 415: largest legal top-left Y (479 − 64).
- `RESPAWN_FRAMES`, default 60: frames between eat and next spawn.
- `MAX_RETRIES`, default 15: overlap re-rolls before fallback.
- `FALLBACK_X`, default 288: X used when retries are exhausted.
- `FALLBACK_Y`, default 64: Y used when retries are exhausted.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse at each frame start.
- `enable`  in  1  game running; 0 holds the FSM in IDLE.
- `fruitOverlap`  in  1  fruit pixel coincides with a scenery pixel this cycle.
- `monkeyCollision`  in  1  monkey touches the fruit this cycle.
- `randomX`  out  11  candidate/committed top-left X.
- `randomY`  out  11  candidate/committed top-left Y.
- `illegalPlacement`  out  1  one-cycle load strobe to the fruit.
- `fruitLive`  out  1  fruit committed and edible.
- `fruitsEaten`  out  8  eat counter, saturating at 255.
- `retryCount`  out  4  re-rolls used for the current spawn.

## Operation
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Shift left with `lfsr[0] <= lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]`. Advances exactly once per cycle in DRAW only.
- Candidate: `cx = {1'b0, lfsr[9:0]}`, `cy = {2'b0, lfsr[15:7]}`.
- States:
  - IDLE: go to DRAW when `enable` = 1.
  - DRAW: accept the candidate if `X_MIN ≤ cx ≤ X_MAX` and `Y_MIN ≤ cy ≤ Y_MAX`. On accept, latch `randomX`/`randomY` and go to LOAD. Otherwise stay in DRAW. Range rejects do not count as retries.
  - LOAD: drive `illegalPlacement` = 1 for exactly one cycle, clear the overlap sticky, go to ARM.
  - ARM: wait for `startOfFrame`, then go to PROBE.
  - PROBE: OR `fruitOverlap` into the sticky. On the next `startOfFrame`, decide:
    - sticky = 0: go to LIVE.
    - sticky = 1 and `retryCount < MAX_RETRIES`: `retryCount++`, go to DRAW.
    - sticky = 1 and `retryCount = MAX_RETRIES`: latch `FALLBACK_X`/`FALLBACK_Y`, go to FORCE.
  - FORCE: one-cycle `illegalPlacement` pulse, then LIVE. No probe is performed.
  - LIVE: `fruitLive` = 1. On `monkeyCollision`, increment `fruitsEaten` (saturating), load the frame counter with `RESPAWN_FRAMES`, go to WAIT.
  - WAIT: decrement the counter on each `startOfFrame`. When it reaches 0, clear `retryCount` and go to DRAW.
- `enable` = 0 in any state: go to IDLE on the next edge. `fruitLive` = 0, `retryCount` cleared, `fruitsEaten` and LFSR kept.
- `monkeyCollision` outside LIVE is ignored.
- `fruitOverlap` outside PROBE is ignored.

## Timing
- Reset values: state IDLE, LFSR = `LFSR_SEED`, `randomX` = `FALLBACK_X`, `randomY` = `FALLBACK_Y`, `illegalPlacement` 0, `fruitLive` 0, `fruitsEaten` 0, `retryCount` 0. Reset takes effect immediately, mid-frame or mid-probe.
- All outputs are registered.
- `randomX`/`randomY` are stable from the cycle before `illegalPlacement` rises until the next DRAW or FORCE.
- `illegalPlacement` is high for exactly 1 cycle per LOAD or FORCE, never back-to-back.
- Probe window spans one complete frame: from the ARM-exit `startOfFrame` (exclusive) to the next `startOfFrame` (inclusive of `fruitOverlap` in that same cycle).
- `startOfFrame` in the LOAD cycle is not counted; ARM waits for a later pulse.
- Minimum spawn latency from DRAW accept to `fruitLive`: LOAD (1) + ARM + one full frame + 1 cycle.
- `fruitLive` falls the cycle after the `monkeyCollision` sample. In LIVE, eat wins over `enable` falling in the same cycle only for the `fruitsEaten` increment; the state still goes to IDLE.
- `RESPAWN_FRAMES` = 0: WAIT exits on the first cycle without waiting for a frame pulse.

## Test plan
- Reset, `enable` = 1, `fruitOverlap` = 0, pulse `startOfFrame` every 1000 cycles. Required: first in-range candidate from seed ACE1 appears on `randomX`/`randomY`, one `illegalPlacement` pulse, `fruitLive` = 1 one cycle after the second frame pulse, `retryCount` = 0.
- Hold `fruitOverlap` = 1 for the whole probe frame, then 0. Required: `retryCount` = 1, a new distinct coordinate, a second `illegalPlacement` pulse, then `fruitLive` = 1.
- Hold `fruitOverlap` = 1 permanently. Required: 15 re-rolls, then `randomX` = 288, `randomY` = 64 with a FORCE pulse and `fruitLive` = 1 with `retryCount` = 15.
- In LIVE, pulse `monkeyCollision` with `RESPAWN_FRAMES` = 3. Required: `fruitsEaten` = 1, `fruitLive` = 0, no `illegalPlacement` before the 3rd subsequent `startOfFrame`, then a new spawn.
- Eat 256 times with `RESPAWN_FRAMES` = 0. Required: `fruitsEaten` saturates at 255.
- Assert `resetN` = 0 mid-PROBE, and separately drop `enable` mid-WAIT. Required: all outputs return to reset values immediately on reset; on `enable` drop the FSM goes to IDLE with `fruitsEaten` retained, and restarts at DRAW when `enable` returns.
